// File: rtl/regfile_mul_seq.sv
// Sequential DW x DW unsigned shift-add multiplier beside a 2**AW-entry register file.
// Optional MUL_EARLY_EXIT_EN: leave MUL as soon as the remaining multiplier bits are zero.
module regfile_mul_seq #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] rs_a,
    input  logic [AW-1:0] rs_b,
    input  logic [AW-1:0] rd,
    input  logic [DW-1:0] op_a,
    input  logic [DW-1:0] op_b,
    output logic [AW-1:0] r_addr1,
    output logic [AW-1:0] r_addr2,
    output logic          wen,
    output logic [AW-1:0] w_addr,
    output logic [DW-1:0] w_data,
    output logic          busy,
    output logic          done
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        WR_LO,
        WR_HI
    } state_t;

    state_t          state;
    logic [DW-1:0]   mcand;
    logic [DW-1:0]   mplier;
    logic [2*DW-1:0] prod;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   ra_q;
    logic [AW-1:0]   rb_q;
    logic [AW-1:0]   dst;

    logic [2*DW-1:0] prod_nxt;
    logic [DW-1:0]   mplier_sh;
    logic            mul_last;
    logic [AW-1:0]   dst_lo;

    // Read addresses follow the request while idle, then hold the captured indices.
    always_comb begin
        r_addr1 = ra_q;
        r_addr2 = rb_q;
        if (state == IDLE) begin
            r_addr1 = rs_a;
            r_addr2 = rs_b;
        end
    end

    // One shift-add step and the decision whether this is the last MUL cycle.
    always_comb begin
        prod_nxt  = prod;
        if (mplier[0]) begin
            prod_nxt = prod + ({{DW{1'b0}}, mcand} << cnt);
        end
        mplier_sh = mplier >> 1;
`ifdef MUL_EARLY_EXIT_EN
        mul_last  = (cnt == CNT_LAST) || (mplier_sh == '0);
`else
        mul_last  = (cnt == CNT_LAST);
`endif
    end

    // Low byte goes to the partner register; wraps around the file.
    assign dst_lo = dst + AW'(1);
    assign busy   = (state != IDLE);

    // Control FSM, datapath registers and registered write-port outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
            ra_q   <= '0;
            rb_q   <= '0;
            dst    <= '0;
            wen    <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
            done   <= 1'b0;
        end else begin
            wen    <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
            done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= op_a;
                        mplier <= op_b;
                        ra_q   <= rs_a;
                        rb_q   <= rs_b;
                        dst    <= rd;
                        prod   <= '0;
                        cnt    <= '0;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    prod   <= prod_nxt;
                    mplier <= mplier_sh;
                    cnt    <= cnt + CW'(1);
                    if (mul_last) begin
                        wen    <= 1'b1;
                        w_addr <= dst_lo;
                        w_data <= prod_nxt[DW-1:0];
                        state  <= WR_LO;
                    end
                end
                WR_LO: begin
                    wen    <= 1'b1;
                    w_addr <= dst;
                    w_data <= prod[2*DW-1:DW];
                    done   <= 1'b1;
                    state  <= WR_HI;
                end
                WR_HI: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
